// File: rtl/mul_final_add_pkg.sv
// Shared widths, op encodings and the stage-1 payload for the multiplier back end.
package mul_final_add_pkg;

  localparam int unsigned W      = 132;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned SPLIT  = 66;
  localparam int unsigned HI_W   = W - SPLIT;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned PROD_W = 128;

  localparam logic [OP_W-1:0] MUL_OP_MUL    = 3'd0;
  localparam logic [OP_W-1:0] MUL_OP_MULH   = 3'd1;
  localparam logic [OP_W-1:0] MUL_OP_MULHSU = 3'd2;
  localparam logic [OP_W-1:0] MUL_OP_MULHU  = 3'd3;
  localparam logic [OP_W-1:0] MUL_OP_MULW   = 3'd4;

  // Stage-1 register contents: resolved low half plus carry, raw upper halves, op.
  typedef struct packed {
    logic [SPLIT-1:0] lo;
    logic             c;
    logic [HI_W-1:0]  hs;
    logic [HI_W-1:0]  hc;
    logic [OP_W-1:0]  op;
  } stage1_t;

endpackage

// File: rtl/mul_res_sel.sv
// Combinational result selector: picks the XLEN slice of the product for the given op.
module mul_res_sel
  import mul_final_add_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [PROD_W-1:0] p,
  output logic [XLEN-1:0]   result_c
);

  // Low word by default, high word for the MULH family, sign-extended low 32 for MULW.
  always_comb begin
    result_c = p[XLEN-1:0];
    case (op)
      MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: result_c = p[2*XLEN-1:XLEN];
      MUL_OP_MULW:                              result_c = {{32{p[31]}}, p[31:0]};
      default:                                  ;
    endcase
  end

endmodule

// File: rtl/mul_final_add.sv
// Two-stage split carry-propagate adder resolving the Wallace (s, cout) pair,
// with valid/ready handshake, backpressure and flush.
module mul_final_add
  import mul_final_add_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     s,
  input  logic [W-1:0]     cout,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result
);

  logic              v1;
  logic              v2;
  stage1_t           st1;
  logic              accept;
  logic              advance;
  logic [PROD_W-1:0] p;
  logic [XLEN-1:0]   sel_res;

  assign in_ready  = ~v1 | ~v2 | out_ready;
  assign accept    = in_valid & in_ready;
  assign advance   = v1 & (~v2 | out_ready);
  assign out_valid = v2;

  // Upper half finishes the add with the stage-1 carry; bits above PROD_W are dropped.
  assign p = PROD_W'({st1.hs + st1.hc + HI_W'(st1.c), st1.lo});

  mul_res_sel u_res_sel (
    .op       (st1.op),
    .p        (p),
    .result_c (sel_res)
  );

  // Stage 1 data: resolve the low SPLIT bits, park the upper halves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st1 <= '0;
    end else if (accept) begin
      {st1.c, st1.lo} <= (SPLIT+1)'(s[SPLIT-1:0]) + (SPLIT+1)'(cout[SPLIT-1:0]);
      st1.hs          <= s[W-1:SPLIT];
      st1.hc          <= cout[W-1:SPLIT];
      st1.op          <= op;
    end
  end

  // Stage 2 data: capture the selected result when stage 1 advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (advance) begin
      result <= sel_res;
    end
  end

  // Valid bits: flush wins over accept/advance; an advance refills v2 on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (accept) begin
        v1 <= 1'b1;
      end else if (advance) begin
        v1 <= 1'b0;
      end
      if (advance) begin
        v2 <= 1'b1;
      end else if (v2 & out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

endmodule
